data_ram_wbuf: RTL and testbench
================================

# data_ram_wbuf

Word-addressed data memory with a posted write buffer, sitting directly downstream of the processor's memory stage on its RAM port (`ram_read`, `ram_write`, `ram_adr`, `ram_data`, `ram_word`). Stores are accepted into a small FIFO and retired into a single-port storage array during cycles with no load. Loads are answered in the same cycle, with forwarding from the buffer so software always sees program-order memory.

## Interface
- `ADDR_W`, 10: word-index width; array holds 2^ADDR_W 32-bit words.
- `WB_DEPTH`, 4: write-buffer entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `ram_read`  in  1  load request this cycle.
- `ram_write`  in  1  store request this cycle.
- `ram_adr`  in  32  byte address; bits [ADDR_W+1:2] select the word; bits [1:0] and [31:ADDR_W+2] are ignored (aliasing).
- `ram_data`  in  32  store data.
- `ram_word`  out  32  load data, combinational.
- `ram_busy`  out  1  store not accepted this cycle; requester must hold the request.
- `wb_empty`  out  1  write buffer holds no entries.

## Operation
- Buffer is a circular FIFO of {index, data} with head/tail pointers wrapping modulo WB_DEPTH and `count` of width clog2(WB_DEPTH+1).
- Accept: `acc = ram_write & ~ram_busy`. On the edge, the entry is written at tail, tail increments.
- Drain: `drn = (count != 0) & ~ram_read`. On the edge, the head entry is written to the array, head increments. This is the only array write path. Loads own the array port in every cycle with `ram_read`=1.
- `count_next = count + acc - drn`. Never exceeds WB_DEPTH and never underflows.
- `ram_busy = ram_write & (count == WB_DEPTH) & ram_read`. When full with no load, drain and accept occur on the same edge, so the store is not stalled.
- Load data when `ram_read`=1: the youngest valid buffer entry whose index matches wins. Otherwise array[index] is returned. A store presented in the same cycle is not visible to that load.
- `ram_word` = 0 when `ram_read`=0.
- Multiple buffered stores to the same index are kept as separate entries. Drain order preserves program order, so the array ends with the last value.
- `wb_empty = (count == 0)`.

## Timing
- Reset (async assert, sync-to-clk release by the integrator): head=tail=count=0, `wb_empty`=1, `ram_busy`=0, `ram_word`=0 (no read). Array contents are not reset.
- Reset asserted mid-operation discards all buffered stores; they never reach the array.
- Load latency: 0 cycles (combinational from `ram_adr`/`ram_read`).
- Store visibility: accepted at edge N, forwarded to loads from cycle N+1, resident in the array no earlier than edge N+1.
- Drain rate: at most one entry per cycle. A continuous `ram_read` stream blocks draining indefinitely. This is allowed; stores only stall once the buffer is full.
- Simultaneous drain and accept when count=WB_DEPTH: both happen, count stays WB_DEPTH.
- Simultaneous drain of entry X and a load of X's index: the load is blocked from draining by definition (`ram_read`=1), so forwarding from the buffer serves it.
- `ram_read` and `ram_write` both high: the load is served first per the above rules, and the store follows the normal accept rule.

## Test plan
- Reset, store 0xDEADBEEF to 0x40, next cycle load 0x40 -> `ram_word`=0xDEADBEEF (forwarded). After 1 idle cycle, `wb_empty`=1 and load 0x40 still returns 0xDEADBEEF from the array.
- Store 0x11 then 0x22 to address 0x80 on consecutive cycles, load 0x80 immediately after -> 0x22. Drain fully, load again -> 0x22.
- WB_DEPTH=4: hold `ram_read`=1 while issuing 5 stores -> first 4 accepted, 5th sees `ram_busy`=1 until `ram_read` drops. It is then accepted with count staying 4, and all 5 values land in the array in order.
- Fill the buffer with 4 stores, assert `rst` low mid-drain -> `wb_empty`=1 and `ram_busy`=0 immediately. Loads of the undrained addresses return the prior array contents.
- Address aliasing: store 0x5A to 0x0000_1004 (ADDR_W=10), load 0x0000_0004 and 0x0000_0007 -> both 0x5A.
- Load with `ram_read`=0 at any state -> `ram_word`=0. Tail/head wrap: 10 stores with interleaved idle cycles -> all values read back correctly.

Source files
------------

// File: rtl/data_ram_wbuf.sv
// Word-addressed data RAM with a posted write buffer. Stores are queued and retire
// into the array on load-free cycles; loads forward from the buffer (youngest match).
module data_ram_wbuf #(
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [31:0] ram_adr,
    input  logic [31:0] ram_data,
    output logic [31:0] ram_word,
    output logic        ram_busy,
    output logic        wb_empty
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [31:0]       data;
    } wb_entry_t;

    logic [31:0]       mem [2**ADDR_W];
    wb_entry_t         wb_q [WB_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] idx;
    logic              acc, drn;
    logic              fwd_hit;
    logic [31:0]       fwd_data;
    logic              unused_adr_bits;

    assign idx             = ram_adr[ADDR_W+1:2];
    assign unused_adr_bits = ^{ram_adr[31:ADDR_W+2], ram_adr[1:0]};

    // A full buffer only stalls a store when a load also holds the array port.
    assign ram_busy   = ram_write & (count == CNT_W'(WB_DEPTH)) & ram_read;
    assign acc        = ram_write & ~ram_busy;
    assign drn        = (count != '0) & ~ram_read;
    assign wb_empty   = (count == '0);
    assign count_next = count + CNT_W'(acc) - CNT_W'(drn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (acc) tail <= tail + PTR_W'(1);
            if (drn) head <= head + PTR_W'(1);
            count <= count_next;
        end
    end

    // Storage is not reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (acc) wb_q[tail] <= {idx, ram_data};
        if (drn) mem[wb_q[head].idx] <= wb_q[head].data;
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (wb_q[head + PTR_W'(k)].idx == idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_q[head + PTR_W'(k)].data;
            end
        end
    end

    always_comb begin
        ram_word = '0;
        if (ram_read) ram_word = fwd_hit ? fwd_data : mem[idx];
    end

endmodule

// File: tb/tb_data_ram_wbuf.sv
// Directed bench for data_ram_wbuf: program-order memory model feeds an expected-value
// queue that is popped when the combinational load result is sampled.
module tb_data_ram_wbuf;
    localparam int ADDR_W   = 10;
    localparam int WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_read = 1'b0;
    logic        ram_write = 1'b0;
    logic [31:0] ram_adr = '0;
    logic [31:0] ram_data = '0;
    logic [31:0] ram_word;
    logic        ram_busy;
    logic        wb_empty;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mdl [2**ADDR_W];

    data_ram_wbuf #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_adr(ram_adr), .ram_data(ram_data),
        .ram_word(ram_word), .ram_busy(ram_busy), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at posedge+1, sample at negedge, advance to next posedge+1.
    task automatic cyc(input string tag, input logic rd, input logic wr,
                       input logic [31:0] adr, input logic [31:0] data, input logic exp_busy);
        logic [ADDR_W-1:0] i;
        i = adr[ADDR_W+1:2];
        ram_read = rd; ram_write = wr; ram_adr = adr; ram_data = data;
        exp_q.push_back(rd ? mdl[i] : 32'h0);
        @(negedge clk);
        check({tag, "/word"}, ram_word, exp_q.pop_front());
        check({tag, "/busy"}, {31'b0, ram_busy}, {31'b0, exp_busy});
        if (wr && !exp_busy) mdl[i] = data;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc("idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic chk_empty(input string tag, input logic exp);
        check({tag, "/wb_empty"}, {31'b0, wb_empty}, {31'b0, exp});
    endtask

    initial begin
        // Reset state
        ram_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_empty("reset", 1'b1);
        check("reset/busy", {31'b0, ram_busy}, 32'h0);
        check("reset/word", ram_word, 32'h0);
        ram_write = 1'b0;
        rst = 1'b1;

        // Store then forwarded load, then array load after drain
        cyc("st40", 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
        cyc("ld40_fwd", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk_empty("ld40_fwd", 1'b0);
        idle(1);
        chk_empty("drained40", 1'b1);
        cyc("ld40_arr", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

        // Two stores to one index; youngest forwarded, array ends with last value
        cyc("st80a", 1'b0, 1'b1, 32'h80, 32'h11, 1'b0);
        cyc("st80b_ld", 1'b1, 1'b1, 32'h80, 32'h22, 1'b0);
        cyc("ld80_fwd", 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
        idle(3);
        chk_empty("drained80", 1'b1);
        cyc("ld80_arr", 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);

        // Full buffer under continuous loads; prior contents first
        for (int k = 0; k < 5; k++) begin
            cyc("pre_full", 1'b0, 1'b1, 32'h100 + 32'(4*k), 32'h9000 + 32'(k), 1'b0);
            idle(1);
        end
        for (int k = 0; k < 4; k++)
            cyc("fill", 1'b1, 1'b1, 32'h100 + 32'(4*k), 32'hA0 + 32'(k), 1'b0);
        cyc("stall1", 1'b1, 1'b1, 32'h110, 32'hA4, 1'b1);
        cyc("stall2", 1'b1, 1'b1, 32'h110, 32'hA4, 1'b1);
        cyc("drop_rd", 1'b0, 1'b1, 32'h110, 32'hA4, 1'b0);
        chk_empty("full_after_drop", 1'b0);
        idle(5);
        chk_empty("full_drained", 1'b1);
        for (int k = 0; k < 5; k++)
            cyc("full_rb", 1'b1, 1'b0, 32'h100 + 32'(4*k), 32'h0, 1'b0);

        // Reset mid-drain discards buffered stores
        for (int k = 0; k < 5; k++) begin
            cyc("pre_rst", 1'b0, 1'b1, 32'h200 + 32'(4*k), 32'hB000 + 32'(k), 1'b0);
            idle(1);
        end
        for (int k = 0; k < 4; k++)
            cyc("rst_fill", 1'b1, 1'b1, 32'h200 + 32'(4*k), 32'hC0 + 32'(k), 1'b0);
        cyc("rst_drain_acc", 1'b0, 1'b1, 32'h210, 32'hC4, 1'b0);
        chk_empty("rst_full", 1'b0);
        ram_read = 1'b1; ram_write = 1'b1; ram_adr = 32'h214; ram_data = 32'hFF;
        #1;
        check("pre_rst/busy", {31'b0, ram_busy}, 32'h1);
        rst = 1'b0;
        #1;
        check("in_rst/busy", {31'b0, ram_busy}, 32'h0);
        chk_empty("in_rst", 1'b1);
        ram_read = 1'b0;
        #1;
        check("in_rst/word", ram_word, 32'h0);
        @(posedge clk); #1;
        ram_write = 1'b0;
        rst = 1'b1;
        // Only C0 retired before reset; the rest keep their prior contents.
        mdl[(32'h200 >> 2)] = 32'hC0;
        for (int k = 1; k < 5; k++) mdl[(32'h200 >> 2) + k] = 32'hB000 + 32'(k);
        for (int k = 0; k < 5; k++)
            cyc("rst_rb", 1'b1, 1'b0, 32'h200 + 32'(4*k), 32'h0, 1'b0);

        // Address aliasing
        cyc("alias_st", 1'b0, 1'b1, 32'h0000_1004, 32'h5A, 1'b0);
        cyc("alias_ld4", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        cyc("alias_ld7", 1'b1, 1'b0, 32'h0000_0007, 32'h0, 1'b0);
        idle(1);
        cyc("alias_arr", 1'b1, 1'b0, 32'h0000_0007, 32'h0, 1'b0);

        // Pointer wrap over ten stores
        for (int k = 0; k < 10; k++) begin
            cyc("wrap_st", 1'b0, 1'b1, 32'h400 + 32'(4*k), 32'h1111 * 32'(k + 1), 1'b0);
            cyc("wrap_fwd", 1'b1, 1'b0, 32'h400 + 32'(4*k), 32'h0, 1'b0);
            idle(1);
        end
        chk_empty("wrap_done", 1'b1);
        for (int k = 0; k < 10; k++)
            cyc("wrap_rb", 1'b1, 1'b0, 32'h400 + 32'(4*k), 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
